izhikevich_pipe_mux: RTL and testbench

//  Parametrised, time-multiplexed Izhikevich neuron update pipeline. Each accepted beat carries one neuron's

---
 rtl/izhikevich_pipe_mux.sv | 210 +++++++++++++++++++++
 tb/tb_izhikevich_pipe_mux.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izhikevich_pipe_mux.sv
// izhikevich_pipe_mux
//   Time-multiplexed Izhikevich neuron update pipeline. Each accepted beat
//   carries one neuron's state (v,u), parameters (a,b,c,d), input current i
//   and an ID tag. Four clocks after acceptance the next (v,u), the fired flag
//   and the tag appear at the output. Valid/ready backpressure stalls the
//   whole pipe; bubbles travel as valid=0. A saturating counter tallies fired
//   results handed off downstream.
//
//   Build option: define IZH_SAT_EN to saturate every add/sub/multiply
//   narrowing. Without it, narrowing keeps the low WIDTH bits (wrap).
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     input handshake
//   in_nid                  neuron-ID tag
//   in_a..in_d              model parameters
//   in_v, in_u, in_i        membrane potential, recovery variable, current
//   out_valid / out_ready   output handshake
//   out_nid, out_v, out_u   result tag and next state
//   out_fired               spike on this update
//   spike_count             fired results handed off since reset
module izhikevich_pipe_mux #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 8,
  parameter int NID_W = 10,
  parameter int CNT_W = 32,
  parameter int VTH   = 30 << FRAC,
  parameter int K2    = 10,
  parameter int K1    = 5 << FRAC,
  parameter int K0    = 140 << FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NID_W-1:0] in_nid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_v,
  input  logic [WIDTH-1:0] in_u,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NID_W-1:0] out_nid,
  output logic [WIDTH-1:0] out_v,
  output logic [WIDTH-1:0] out_u,
  output logic             out_fired,
  output logic [CNT_W-1:0] spike_count
);

  typedef logic signed [WIDTH-1:0]   dat_t;
  typedef logic signed [WIDTH:0]     ext_t;
  typedef logic signed [2*WIDTH-1:0] wide_t;

`ifdef IZH_SAT_EN
  localparam dat_t MAX_V = dat_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam dat_t MIN_V = dat_t'({1'b1, {(WIDTH-1){1'b0}}});
`endif

  // Narrow a WIDTH+1 sum: overflow shows as disagreement of the top two bits.
  function automatic dat_t sat_n(input ext_t x);
`ifdef IZH_SAT_EN
    if (x[WIDTH] != x[WIDTH-1]) return x[WIDTH] ? MIN_V : MAX_V;
`endif
    return dat_t'(x);
  endfunction

  function automatic dat_t add_n(input dat_t x, input dat_t y);
    return sat_n(ext_t'(x) + ext_t'(y));
  endfunction

  function automatic dat_t sub_n(input dat_t x, input dat_t y);
    return sat_n(ext_t'(x) - ext_t'(y));
  endfunction

  // Full-width product, floor shift, then narrow. The shifted value fits in
  // WIDTH bits only if bits [2W-1:W-1] are all equal.
  function automatic dat_t mul_n(input dat_t x, input dat_t y);
    wide_t p;
    p = (wide_t'(x) * wide_t'(y)) >>> FRAC;
`ifdef IZH_SAT_EN
    if (!p[2*WIDTH-1] && (|p[2*WIDTH-2:WIDTH-1])) return MAX_V;
    if (p[2*WIDTH-1] && !(&p[2*WIDTH-2:WIDTH-1])) return MIN_V;
`endif
    return dat_t'(p);
  endfunction

  // r0: captured beat; r1..r3: arithmetic stages 1..3; ro: stage 4 outputs.
  typedef struct packed {
    logic vld; logic [NID_W-1:0] nid;
    dat_t a, b, c, d, v, u, i;
  } r0_t;
  typedef struct packed {
    logic vld; logic [NID_W-1:0] nid;
    dat_t a, c, d, v, u, i, k2v, k1v, bv;
  } r1_t;
  typedef struct packed {
    logic vld; logic [NID_W-1:0] nid;
    dat_t a, c, d, v, u, i, q, k1v, bvu;
  } r2_t;
  typedef struct packed {
    logic vld; logic [NID_W-1:0] nid;
    dat_t c, d, v, u, i, s, am;
  } r3_t;
  typedef struct packed {
    logic vld; logic [NID_W-1:0] nid;
    dat_t v, u; logic fired;
  } ro_t;

  r0_t r0_q, r0_d;
  r1_t r1_q, r1_d;
  r2_t r2_q, r2_d;
  r3_t r3_q, r3_d;
  ro_t ro_q, ro_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dat_t nv_c;
  logic fire_c;
  logic stall;

  assign stall    = ro_q.vld & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    r0_d.vld = in_valid;
    r0_d.nid = in_nid;
    r0_d.a   = dat_t'(in_a);
    r0_d.b   = dat_t'(in_b);
    r0_d.c   = dat_t'(in_c);
    r0_d.d   = dat_t'(in_d);
    r0_d.v   = dat_t'(in_v);
    r0_d.u   = dat_t'(in_u);
    r0_d.i   = dat_t'(in_i);

    r1_d.vld = r0_q.vld;
    r1_d.nid = r0_q.nid;
    r1_d.a   = r0_q.a;
    r1_d.c   = r0_q.c;
    r1_d.d   = r0_q.d;
    r1_d.v   = r0_q.v;
    r1_d.u   = r0_q.u;
    r1_d.i   = r0_q.i;
    r1_d.k2v = mul_n(dat_t'(K2), r0_q.v);
    r1_d.k1v = mul_n(dat_t'(K1), r0_q.v);
    r1_d.bv  = mul_n(r0_q.b, r0_q.v);

    r2_d.vld = r1_q.vld;
    r2_d.nid = r1_q.nid;
    r2_d.a   = r1_q.a;
    r2_d.c   = r1_q.c;
    r2_d.d   = r1_q.d;
    r2_d.v   = r1_q.v;
    r2_d.u   = r1_q.u;
    r2_d.i   = r1_q.i;
    r2_d.q   = mul_n(r1_q.k2v, r1_q.v);
    r2_d.k1v = r1_q.k1v;
    r2_d.bvu = sub_n(r1_q.bv, r1_q.u);

    r3_d.vld = r2_q.vld;
    r3_d.nid = r2_q.nid;
    r3_d.c   = r2_q.c;
    r3_d.d   = r2_q.d;
    r3_d.v   = r2_q.v;
    r3_d.u   = r2_q.u;
    r3_d.i   = r2_q.i;
    r3_d.s   = sub_n(add_n(add_n(r2_q.q, r2_q.k1v), dat_t'(K0)), r2_q.u);
    r3_d.am  = mul_n(r2_q.a, r2_q.bvu);

    nv_c     = add_n(add_n(r3_q.s, r3_q.i), r3_q.v);
    fire_c   = (nv_c >= dat_t'(VTH));
    ro_d.vld   = r3_q.vld;
    ro_d.nid   = r3_q.nid;
    ro_d.fired = r3_q.vld & fire_c;
    ro_d.v     = fire_c ? r3_q.c : nv_c;
    ro_d.u     = fire_c ? add_n(r3_q.u, r3_q.d) : add_n(r3_q.u, r3_q.am);

    cnt_d = cnt_q;
    if (ro_q.vld && out_ready && ro_q.fired && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      ro_q <= '0;
    end else if (!stall) begin
      r0_q <= r0_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      ro_q <= ro_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid   = ro_q.vld;
  assign out_nid     = ro_q.nid;
  assign out_v       = ro_q.v;
  assign out_u       = ro_q.u;
  assign out_fired   = ro_q.fired;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_izhikevich_pipe_mux.sv
module tb_izhikevich_pipe_mux;
  localparam int W    = 20;
  localparam int NW   = 10;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [NW-1:0] in_nid = '0;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0, in_v = '0, in_u = '0, in_i = '0;
  logic out_valid, out_ready = 1'b1;
  logic [NW-1:0] out_nid;
  logic [W-1:0] out_v, out_u;
  logic out_fired;
  logic [CW-1:0] spike_count;

  izhikevich_pipe_mux #(.WIDTH(W), .FRAC(8), .NID_W(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_nid(in_nid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_v(in_v), .in_u(in_u), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_nid(out_nid), .out_v(out_v),
    .out_u(out_u), .out_fired(out_fired), .spike_count(spike_count));

  always #5 clk = ~clk;

  typedef struct { int a, b, c, d, v, u, i; } beat_t;
  typedef struct { string tag; int nid; int v; int u; bit fired; } res_t;
  typedef struct { string name; beat_t bt; bit f; int ev; int eu; } vec_t;

  res_t sb[$];
  res_t cur_exp;
  vec_t tbl[8];
  int nchk = 0, nerr = 0, exp_cnt = 0, cyc_no = 0, hand_cnt = 0, stall_cnt = 0;
  bit pat_en = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic longint nw(input longint x);
`ifdef IZH_SAT_EN
    if (x > 524287) return 524287;
    if (x < -524288) return -524288;
    return x;
`else
    longint m;
    m = x % 1048576;
    if (m < 0) m += 1048576;
    if (m >= 524288) m -= 1048576;
    return m;
`endif
  endfunction

  function automatic longint fmul(input longint x, input longint y);
    return nw((x * y) >>> 8);
  endfunction

  function automatic res_t model(input beat_t bt, input int nid, input string tag);
    longint k2v, k1v, bv, q, bvu, s, am, nv;
    res_t r;
    k2v = fmul(10, bt.v);
    k1v = fmul(1280, bt.v);
    bv  = fmul(bt.b, bt.v);
    q   = fmul(k2v, bt.v);
    bvu = nw(bv - bt.u);
    s   = nw(nw(nw(q + k1v) + 35840) - bt.u);
    am  = fmul(bt.a, bvu);
    nv  = nw(nw(s + bt.i) + bt.v);
    r.tag   = tag;
    r.nid   = nid;
    r.fired = (nv >= 7680);
    r.v     = r.fired ? bt.c : int'(nv);
    r.u     = r.fired ? int'(nw(longint'(bt.u) + bt.d)) : int'(nw(longint'(bt.u) + am));
    return r;
  endfunction

  function automatic beat_t mkb(input int a, b, c, d, v, u, i);
    beat_t bt;
    bt.a = a; bt.b = b; bt.c = c; bt.d = d; bt.v = v; bt.u = u; bt.i = i;
    return bt;
  endfunction

  function automatic vec_t mkv(input string n, input beat_t bt, input bit f, input int ev, eu);
    vec_t t;
    t.name = n; t.bt = bt; t.f = f; t.ev = ev; t.eu = eu;
    return t;
  endfunction

  function automatic res_t mkr(input string tag, input int nid, input bit f, input int v, u);
    res_t r;
    r.tag = tag; r.nid = nid; r.fired = f; r.v = v; r.u = u;
    return r;
  endfunction

  // One clock: check any handoff before the edge, book acceptance after it.
  task automatic cyc(output bit acc);
    bit ho;
    res_t r;
    if (pat_en) out_ready = (cyc_no % 3) != 0;
    #1;
    acc = in_valid && in_ready;
    ho  = out_valid && out_ready;
    if (out_valid && !out_ready) stall_cnt++;
    if (out_valid) chk("out_valid_has_pending", sb.size() > 0, 1);
    if (ho && sb.size() > 0) begin
      r = sb.pop_front();
      hand_cnt++;
      chk({r.tag, ".nid"}, out_nid, r.nid);
      chk({r.tag, ".fired"}, out_fired, r.fired);
      chk({r.tag, ".v"}, $signed(out_v), r.v);
      chk({r.tag, ".u"}, $signed(out_u), r.u);
      if (r.fired && exp_cnt < CMAX) exp_cnt++;
    end
    @(posedge clk);
    #1;
    cyc_no++;
    if (acc) sb.push_back(cur_exp);
    chk("spike_count", spike_count, exp_cnt);
  endtask

  task automatic send(input beat_t bt, input res_t e);
    bit acc;
    int n;
    in_a = bt.a[W-1:0]; in_b = bt.b[W-1:0]; in_c = bt.c[W-1:0]; in_d = bt.d[W-1:0];
    in_v = bt.v[W-1:0]; in_u = bt.u[W-1:0]; in_i = bt.i[W-1:0];
    in_nid = e.nid[NW-1:0];
    in_valid = 1'b1;
    cur_exp = e;
    acc = 0;
    n = 0;
    while (!acc && n < 60) begin
      cyc(acc);
      n++;
    end
    if (!acc) timeout({e.tag, ".accept"});
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) cyc(acc);
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      cyc(acc);
      n++;
    end
    if (sb.size() > 0) timeout("drain");
  endtask

  task automatic lat_test(input beat_t bt, input res_t e);
    bit acc;
    int n;
    send(bt, e);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      cyc(acc);
      n++;
    end
    chk({e.tag, ".latency"}, n, 4);
    drain(20);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t fire_b, rest_b, bt;
    bit acc;
    logic [W-1:0] sv, su;
    int h0;

    fire_b = mkb(0, 0, -16640, 2048, 0, 28160, 0);
    rest_b = mkb(5, 51, -16640, 2048, -16640, -3328, 0);

    tbl[0] = mkv("thr_fire",  fire_b, 1, -16640, 30208);
    tbl[1] = mkv("thr_below", mkb(0, 0, -16640, 2048, 0, 28161, 0), 0, 7679, 28161);
    tbl[2] = mkv("rest",      rest_b, 0, -18422, -3328);
    tbl[3] = mkv("rest_i10",  mkb(5, 51, -16640, 2048, -16640, -3328, 2560), 0, -15862, -3328);
    tbl[4] = mkv("recovery",  mkb(5, 51, -16640, 2048, 0, 35840, 0), 0, 0, 35140);
    tbl[5] = mkv("floor_neg", mkb(1, 0, -16640, 2048, 0, 35841, 0), 0, -1, 35700);
    tbl[6] = mkv("thr_i",     mkb(0, 0, -16640, 2048, 0, 28416, 256), 1, -16640, 30464);
`ifdef IZH_SAT_EN
    tbl[7] = mkv("big_v",     mkb(0, 0, -16640, 512, -512000, 0, 0), 0, -476161, 0);
`else
    tbl[7] = mkv("big_v",     mkb(0, 0, -16640, 512, -512000, 0, 0), 1, -16640, 512);
`endif

    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_fired", out_fired, 0);
    chk("reset.spike_count", spike_count, 0);
    chk("reset.out_v", out_v, 0);
    chk("reset.out_u", out_u, 0);
    chk("reset.out_nid", out_nid, 0);
    chk("reset.in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // table of hand-computed vectors, streamed back to back
    for (int k = 0; k < 8; k++)
      send(tbl[k].bt, mkr({"vec_", tbl[k].name}, 100 + k, tbl[k].f, tbl[k].ev, tbl[k].eu));
    drain(30);

    // single-beat latency, then rest-point stream nid 0..7
    lat_test(rest_b, model(rest_b, 9, "latency"));
    for (int k = 0; k < 8; k++) send(rest_b, model(rest_b, k, "rest_stream"));
    drain(30);

    // varied beats with interleaved bubbles
    for (int k = 0; k < 6; k++) begin
      bt = mkb(5 + k, 51 - 4 * k, -16640, 2048, -16640 + 3000 * k, -3328 + 500 * k, 700 * k);
      send(bt, model(bt, 200 + k, "mixed"));
      idle(k % 2);
    end
    drain(30);

    // backpressure: four beats, then three held cycles
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bt = mkb(5, 51, -16640, 2048, -16640 + 1000 * k, -3328, 0);
      send(bt, model(bt, 20 + k, "bp"));
    end
    in_valid = 1'b0;
    h0 = 0;
    while (!out_valid && h0 < 12) begin
      cyc(acc);
      h0++;
    end
    sv = out_v;
    su = out_u;
    for (int k = 0; k < 3; k++) begin
      chk("bp.in_ready", in_ready, 0);
      if (sb.size() > 0) chk("bp.nid_head", out_nid, sb[0].nid);
      chk("bp.v_stable", out_v, sv);
      chk("bp.u_stable", out_u, su);
      cyc(acc);
    end
    h0 = hand_cnt;
    out_ready = 1'b1;
    drain(30);
    chk("bp.handoffs", hand_cnt - h0, 4);

    // spike counter saturation with a pulsed out_ready
    stall_cnt = 0;
    pat_en = 1;
    for (int k = 0; k < 20; k++) send(fire_b, model(fire_b, 40 + k, "cnt"));
    drain(200);
    pat_en = 0;
    out_ready = 1'b1;
    idle(3);
    chk("cnt.saturated", spike_count, CMAX);
    chk("cnt.stalls_seen", stall_cnt >= 5, 1);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) send(fire_b, model(fire_b, 60 + k, "inflight"));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.spike_count", spike_count, 0);
    chk("rst.out_fired", out_fired, 0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rst.no_stale", out_valid, 0);
      cyc(acc);
    end
    lat_test(fire_b, model(fire_b, 70, "post_rst"));
    chk("post_rst.count", spike_count, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
